// File: rtl/ucie_ctl_sb_msg_scheduler_pkg.sv
// Shared definitions for the sideband message scheduler.
// - Decode codes sent to the decoded-message analyser. These values must
//   match the codes the analyser expects.
// - Message index constants. This is the bit position in the request and
//   pending vectors, and it is also the arbitration priority: a higher
//   index wins.
// - Scheduler FSM state encoding.
// - msg_decode(): maps a message index to its decode code.
package ucie_ctl_sb_msg_scheduler_pkg;

  localparam int NUM_MSG = 8;
  localparam int MSG_W   = 3;

  localparam logic [MSG_W-1:0] MSG_IDX_ADV_CAP      = 3'd0;
  localparam logic [MSG_W-1:0] MSG_IDX_REQ_ACTIVE   = 3'd1;
  localparam logic [MSG_W-1:0] MSG_IDX_REQ_LINK_RST = 3'd2;
  localparam logic [MSG_W-1:0] MSG_IDX_RSP_ACTIVE   = 3'd3;
  localparam logic [MSG_W-1:0] MSG_IDX_RSP_LINK_RST = 3'd4;
  localparam logic [MSG_W-1:0] MSG_IDX_ERR_CORR     = 3'd5;
  localparam logic [MSG_W-1:0] MSG_IDX_ERR_NONFATAL = 3'd6;
  localparam logic [MSG_W-1:0] MSG_IDX_ERR_FATAL    = 3'd7;

  localparam logic [4:0] SB_DEC_ADV_CAP      = 5'b00000;
  localparam logic [4:0] SB_DEC_REQ_ACTIVE   = 5'b10101;
  localparam logic [4:0] SB_DEC_REQ_LINK_RST = 5'b10111;
  localparam logic [4:0] SB_DEC_RSP_ACTIVE   = 5'b11001;
  localparam logic [4:0] SB_DEC_RSP_LINK_RST = 5'b11011;
  localparam logic [4:0] SB_DEC_ERR_CORR     = 5'b11100;
  localparam logic [4:0] SB_DEC_ERR_NONFATAL = 5'b11101;
  localparam logic [4:0] SB_DEC_ERR_FATAL    = 5'b11110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENABLE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_TX     = 2'd3
  } sched_state_e;

  function automatic logic [4:0] msg_decode(input logic [MSG_W-1:0] idx);
    logic [4:0] dec;
    case (idx)
      MSG_IDX_ADV_CAP:      dec = SB_DEC_ADV_CAP;
      MSG_IDX_REQ_ACTIVE:   dec = SB_DEC_REQ_ACTIVE;
      MSG_IDX_REQ_LINK_RST: dec = SB_DEC_REQ_LINK_RST;
      MSG_IDX_RSP_ACTIVE:   dec = SB_DEC_RSP_ACTIVE;
      MSG_IDX_RSP_LINK_RST: dec = SB_DEC_RSP_LINK_RST;
      MSG_IDX_ERR_CORR:     dec = SB_DEC_ERR_CORR;
      MSG_IDX_ERR_NONFATAL: dec = SB_DEC_ERR_NONFATAL;
      default:              dec = SB_DEC_ERR_FATAL;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_msg_scheduler_if.sv
// Request/analyser/transmitter signal bundle for the sideband message
// scheduler.
// - master: the scheduler's view of the bundle.
// - slave:  the surrounding logic's view (request sources, the analyser
//           and the SB transmitter).
//
// Signals:
//   i_req        per-message request pulses, one bit per message index
//   i_tx_ack     SB transmitter has accepted the message
//   o_sb_decode  decode code sent to the analyser
//   o_enable     one-cycle capture strobe for the analyser
//   o_tx_start   send request to the transmitter, held until ack
//   o_busy       scheduler is not idle
//   o_pending    current pending-request vector
//   o_grant_id   index of the message in flight
//   o_timeout    one-cycle pulse when a message is dropped for lack of ack
interface ucie_ctl_sb_msg_scheduler_if;
  logic [7:0] i_req;
  logic       i_tx_ack;
  logic [4:0] o_sb_decode;
  logic       o_enable;
  logic       o_tx_start;
  logic       o_busy;
  logic [7:0] o_pending;
  logic [2:0] o_grant_id;
  logic       o_timeout;

  modport master (
    input  i_req, i_tx_ack,
    output o_sb_decode, o_enable, o_tx_start, o_busy, o_pending,
           o_grant_id, o_timeout
  );

  modport slave (
    output i_req, i_tx_ack,
    input  o_sb_decode, o_enable, o_tx_start, o_busy, o_pending,
           o_grant_id, o_timeout
  );
endinterface

// File: rtl/ucie_ctl_sb_prio_enc.sv
// Priority encoder that gives precedence to the highest index.
// Ports:
//   i_vec    request vector
//   o_idx    index of the highest set bit (0 when none is set)
//   o_valid  high when at least one bit of i_vec is set
module ucie_ctl_sb_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  // The scan runs from low to high index, so a later (higher) hit
  // overrides an earlier one.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_msg_scheduler.sv
// Sideband message scheduler. Operation:
// - Latches message requests as pending.
// - Grants the highest pending index.
// - Strobes the decode code into the analyser and allows one settle cycle.
// - Hands the message to the SB transmitter with a start/ack handshake.
// Only one message is in flight at a time. If no ack arrives within
// ACK_TIMEOUT cycles, the message is dropped and o_timeout pulses.
//
// Parameters:
//   ACK_TIMEOUT  TX cycles to wait for ack before dropping the message
//   TMO_CNT_W    timeout counter width (2**TMO_CNT_W > ACK_TIMEOUT)
// Ports:
//   i_clk, i_rst  clock; synchronous active-high reset
//   sb            request/analyser/transmitter bundle (master side)
module ucie_ctl_sb_msg_scheduler
  import ucie_ctl_sb_msg_scheduler_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_CNT_W   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  ucie_ctl_sb_msg_scheduler_if.master   sb
);

  sched_state_e         state_q, state_d;
  logic [NUM_MSG-1:0]   pending_q, pending_d;
  logic [NUM_MSG-1:0]   clr_mask;
  logic [MSG_W-1:0]     grant_q, grant_d;
  logic [4:0]           dec_q, dec_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [MSG_W-1:0]     enc_idx;
  logic                 enc_valid;

  // Arbitration looks at the registered pending vector only. A request
  // arriving in the same cycle becomes visible one cycle later.
  ucie_ctl_sb_prio_enc #(
    .N (NUM_MSG),
    .W (MSG_W)
  ) u_prio_enc (
    .i_vec   (pending_q),
    .o_idx   (enc_idx),
    .o_valid (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    dec_d    = dec_q;
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          grant_d  = enc_idx;
          dec_d    = msg_decode(enc_idx);
          clr_mask = NUM_MSG'(1) << enc_idx;
          state_d  = ST_ENABLE;
        end
      end
      ST_ENABLE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        cnt_d   = '0;
        state_d = ST_TX;
      end
      ST_TX: begin
        if (sb.i_tx_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_CNT_W'(ACK_TIMEOUT - 1)) begin
          // The message is dropped, not re-queued.
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A request that arrives in the grant cycle overrides the clear, so that
    // message is sent again later. A repeated request for a bit that is
    // already pending merges into a single send.
    pending_d = (pending_q & ~clr_mask) | sb.i_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      dec_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign sb.o_sb_decode = dec_q;
  assign sb.o_grant_id  = grant_q;
  assign sb.o_pending   = pending_q;
  assign sb.o_enable    = (state_q == ST_ENABLE);
  assign sb.o_tx_start  = (state_q == ST_TX);
  assign sb.o_busy      = (state_q != ST_IDLE);
  assign sb.o_timeout   = tmo_q;

endmodule

// File: tb/tb_ucie_ctl_sb_msg_scheduler.sv
module tb_ucie_ctl_sb_msg_scheduler;

  logic i_clk;
  logic i_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected sends, stored as {grant_id, decode}. They are pushed when a
  // stimulus step is driven and popped on each o_enable.
  logic [7:0] exp_q[$];

  // Controls for the ack responder.
  logic force_ack = 1'b0;
  int   ack_delay = 0;
  int   tx_cyc    = 0;

  ucie_ctl_sb_msg_scheduler_if sb_if ();

  ucie_ctl_sb_msg_scheduler #(
    .ACK_TIMEOUT (4),
    .TMO_CNT_W   (3)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .sb    (sb_if)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [4:0] dec);
    exp_q.push_back({id, dec});
  endtask

  // Ack responder. It acks on the (ack_delay)-th TX cycle, counting from 0.
  // force_ack holds ack high regardless of the scheduler's state.
  always @(negedge i_clk) begin
    if (sb_if.o_tx_start) begin
      sb_if.i_tx_ack = force_ack || (tx_cyc >= ack_delay);
      tx_cyc++;
    end else begin
      sb_if.i_tx_ack = force_ack;
      tx_cyc = 0;
    end
  end

  // Scoreboard monitor. It checks every analyser strobe against the queue.
  always @(negedge i_clk) begin
    logic [7:0] e;
    if (!i_rst && sb_if.o_enable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_enable", 32'(sb_if.o_enable), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_decode", 32'(sb_if.o_sb_decode), 32'(e[4:0]));
        chk("grant_id",  32'(sb_if.o_grant_id),  32'(e[7:5]));
      end
    end
  end

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!sb_if.o_busy && sb_if.o_pending == 8'h00) break;
      tick();
    end
    chk({tag, "_drain"}, {23'd0, sb_if.o_busy, sb_if.o_pending}, 32'd0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    sb_if.i_req = 8'h00;
    sb_if.i_tx_ack = 1'b0;
    tick();
    tick();
    chk("rst_enable",   32'(sb_if.o_enable),    32'd0);
    chk("rst_tx_start", 32'(sb_if.o_tx_start),  32'd0);
    chk("rst_busy",     32'(sb_if.o_busy),      32'd0);
    chk("rst_pending",  32'(sb_if.o_pending),   32'd0);
    chk("rst_grant",    32'(sb_if.o_grant_id),  32'd0);
    chk("rst_decode",   32'(sb_if.o_sb_decode), 32'd0);
    chk("rst_timeout",  32'(sb_if.o_timeout),   32'd0);
    i_rst = 1'b0;

    // Single request. Ack is forced high throughout, so it must be ignored
    // until the scheduler reaches TX.
    force_ack = 1'b1;
    tick();
    chk("idle_ack_ignored", 32'(sb_if.o_busy), 32'd0);
    push_exp(3'd1, 5'b10101);
    sb_if.i_req = 8'h02;
    tick();
    sb_if.i_req = 8'h00;
    chk("s1_pending", 32'(sb_if.o_pending), 32'h02);
    chk("s1_busy0",   32'(sb_if.o_busy),    32'd0);
    tick();
    chk("s1_enable",   32'(sb_if.o_enable),  32'd1);
    chk("s1_pend_clr", 32'(sb_if.o_pending), 32'h00);
    tick();
    chk("s1_settle_en", 32'(sb_if.o_enable),   32'd0);
    chk("s1_settle_tx", 32'(sb_if.o_tx_start), 32'd0);
    chk("s1_settle_bz", 32'(sb_if.o_busy),     32'd1);
    tick();
    chk("s1_tx_start", 32'(sb_if.o_tx_start), 32'd1);
    tick();
    chk("s1_idle_busy", 32'(sb_if.o_busy),     32'd0);
    chk("s1_idle_tx",   32'(sb_if.o_tx_start), 32'd0);
    force_ack = 1'b0;
    ack_delay = 0;

    // Simultaneous requests: fatal is sent first, then adv_cap.
    push_exp(3'd7, 5'b11110);
    push_exp(3'd0, 5'b00000);
    sb_if.i_req = 8'h81;
    tick();
    sb_if.i_req = 8'h00;
    chk("s2_pend81", 32'(sb_if.o_pending), 32'h81);
    tick();
    chk("s2_pend01", 32'(sb_if.o_pending), 32'h01);
    chk("s2_en7",    32'(sb_if.o_enable),  32'd1);
    tick();
    tick();
    chk("s2_tx", 32'(sb_if.o_tx_start), 32'd1);
    tick();
    chk("s2_gap_busy", 32'(sb_if.o_busy),    32'd0);
    chk("s2_gap_pend", 32'(sb_if.o_pending), 32'h01);
    tick();
    chk("s2_en0",    32'(sb_if.o_enable),  32'd1);
    chk("s2_pend00", 32'(sb_if.o_pending), 32'h00);
    wait_drain("s2");

    // Set/clear collision: bit 1 is pulsed again in its own grant cycle.
    push_exp(3'd1, 5'b10101);
    push_exp(3'd1, 5'b10101);
    sb_if.i_req = 8'h02;
    tick();
    chk("s3_pend", 32'(sb_if.o_pending), 32'h02);
    tick();
    sb_if.i_req = 8'h00;
    chk("s3_en",        32'(sb_if.o_enable),  32'd1);
    chk("s3_pend_kept", 32'(sb_if.o_pending), 32'h02);
    wait_drain("s3");

    // Merge: bit 3 is pulsed three times while the scheduler is busy.
    ack_delay = 2;
    push_exp(3'd5, 5'b11100);
    push_exp(3'd3, 5'b11001);
    sb_if.i_req = 8'h20;
    tick();
    sb_if.i_req = 8'h00;
    tick();
    chk("s4_en5", 32'(sb_if.o_enable), 32'd1);
    sb_if.i_req = 8'h08;
    tick();
    sb_if.i_req = 8'h00;
    tick();
    chk("s4_tx", 32'(sb_if.o_tx_start), 32'd1);
    sb_if.i_req = 8'h08;
    tick();
    sb_if.i_req = 8'h00;
    tick();
    sb_if.i_req = 8'h08;
    tick();
    sb_if.i_req = 8'h00;
    chk("s4_idle", 32'(sb_if.o_busy),    32'd0);
    chk("s4_pend", 32'(sb_if.o_pending), 32'h08);
    wait_drain("s4");

    // Timeout: bit 6 is never acked and is dropped after 4 TX cycles. Bit 4
    // then proceeds.
    ack_delay = 99;
    push_exp(3'd6, 5'b11101);
    push_exp(3'd4, 5'b11011);
    sb_if.i_req = 8'h50;
    tick();
    sb_if.i_req = 8'h00;
    tick();
    chk("s5_en6", 32'(sb_if.o_enable), 32'd1);
    tick();
    tick();
    chk("s5_tx1", 32'(sb_if.o_tx_start), 32'd1);
    tick();
    tick();
    tick();
    chk("s5_tx4",    32'(sb_if.o_tx_start), 32'd1);
    chk("s5_no_tmo", 32'(sb_if.o_timeout),  32'd0);
    tick();
    chk("s5_tmo",      32'(sb_if.o_timeout),  32'd1);
    chk("s5_tmo_busy", 32'(sb_if.o_busy),     32'd0);
    chk("s5_tmo_tx",   32'(sb_if.o_tx_start), 32'd0);
    chk("s5_tmo_pend", 32'(sb_if.o_pending),  32'h10);
    ack_delay = 0;
    tick();
    chk("s5_tmo_off", 32'(sb_if.o_timeout), 32'd0);
    chk("s5_en4",     32'(sb_if.o_enable),  32'd1);
    wait_drain("s5");

    // Reset while in TX with bit 4 still pending.
    ack_delay = 99;
    push_exp(3'd5, 5'b11100);
    sb_if.i_req = 8'h20;
    tick();
    sb_if.i_req = 8'h00;
    tick();
    sb_if.i_req = 8'h10;
    tick();
    sb_if.i_req = 8'h00;
    tick();
    chk("s6_tx",   32'(sb_if.o_tx_start), 32'd1);
    chk("s6_pend", 32'(sb_if.o_pending),  32'h10);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("s6_rst_tx",     32'(sb_if.o_tx_start),  32'd0);
    chk("s6_rst_busy",   32'(sb_if.o_busy),      32'd0);
    chk("s6_rst_pend",   32'(sb_if.o_pending),   32'd0);
    chk("s6_rst_en",     32'(sb_if.o_enable),    32'd0);
    chk("s6_rst_grant",  32'(sb_if.o_grant_id),  32'd0);
    chk("s6_rst_decode", 32'(sb_if.o_sb_decode), 32'd0);
    chk("s6_rst_tmo",    32'(sb_if.o_timeout),   32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s6_no_enable", 32'(sb_if.o_enable), 32'd0);
    end
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
